// File: rtl/mwrite.sv
// Memory-write stage: latches write-back and store requests from the memory-read
// stage, drives the register-file write port and runs the store handshake.
module mwrite (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic [4:0]  MEMR_REG_W_RD,
  input  logic [31:0] MEMR_REG_W_DATA,
  input  logic        MEMR_MEM_W_VALID,
  input  logic [31:0] MEMR_MEM_W_ADDR,
  input  logic [3:0]  MEMR_MEM_W_STRB,
  input  logic [31:0] MEMR_MEM_W_DATA,
  output logic [4:0]  MEMW_REG_W_RD,
  output logic [31:0] MEMW_REG_W_DATA,
  output logic        MEM_W_VALID,
  input  logic        MEM_W_READY,
  output logic [31:0] MEM_W_ADDR,
  output logic [3:0]  MEM_W_STRB,
  output logic [31:0] MEM_W_DATA,
  input  logic        MEM_B_VALID,
  output logic        MEM_B_READY,
  input  logic [1:0]  MEM_B_RESP,
  output logic        MEMW_STALL_REQ,
  output logic        MEMW_FAULT
);

  localparam int unsigned RegW  = 5;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               fault_q, fault_d;
  logic [RegW-1:0]    reg_rd_q;
  logic [DataW-1:0]   reg_data_q;
  logic [DataW-1:0]   st_addr_q;
  logic [StrbW-1:0]   st_strb_q;
  logic [DataW-1:0]   st_data_q;
  logic               capture;

  // Upstream values are only taken while idle and not globally stalled.
  assign capture = !STALL && (state_q == IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_rd_q   <= '0;
      reg_data_q <= '0;
      st_addr_q  <= '0;
      st_strb_q  <= '0;
      st_data_q  <= '0;
    end else if (capture) begin
      reg_rd_q   <= MEMR_REG_W_RD;
      reg_data_q <= MEMR_REG_W_DATA;
      st_addr_q  <= MEMR_MEM_W_ADDR;
      st_strb_q  <= MEMR_MEM_W_STRB;
      st_data_q  <= MEMR_MEM_W_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Store handshake: address/data phase, then response phase; one store at a time.
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture && MEMR_MEM_W_VALID) state_d = REQ;
      end
      REQ: begin
        if (MEM_W_READY) state_d = RESP;
      end
      RESP: begin
        if (MEM_B_VALID) begin
          state_d = IDLE;
          fault_d = (MEM_B_RESP != 2'b00);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MEMW_REG_W_RD   = reg_rd_q;
  assign MEMW_REG_W_DATA = reg_data_q;
  assign MEM_W_VALID     = (state_q == REQ);
  assign MEM_W_ADDR      = (state_q == REQ) ? st_addr_q : '0;
  assign MEM_W_STRB      = (state_q == REQ) ? st_strb_q : '0;
  assign MEM_W_DATA      = (state_q == REQ) ? st_data_q : '0;
  assign MEM_B_READY     = (state_q == RESP);
  assign MEMW_STALL_REQ  = (state_q != IDLE);
  assign MEMW_FAULT      = fault_q;

endmodule

// File: tb/tb_mwrite.sv
// Directed bench for mwrite: write-back pass, store handshakes, faults, stalls, reset.
module tb_mwrite;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL;
  logic        ext_stall;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic        MEMR_MEM_W_VALID;
  logic [31:0] MEMR_MEM_W_ADDR;
  logic [3:0]  MEMR_MEM_W_STRB;
  logic [31:0] MEMR_MEM_W_DATA;
  logic [4:0]  MEMW_REG_W_RD;
  logic [31:0] MEMW_REG_W_DATA;
  logic        MEM_W_VALID;
  logic        MEM_W_READY;
  logic [31:0] MEM_W_ADDR;
  logic [3:0]  MEM_W_STRB;
  logic [31:0] MEM_W_DATA;
  logic        MEM_B_VALID;
  logic        MEM_B_READY;
  logic [1:0]  MEM_B_RESP;
  logic        MEMW_STALL_REQ;
  logic        MEMW_FAULT;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt = 0;

  always #5 CLK = ~CLK;

  // The global stall always includes this block's own request.
  assign STALL = ext_stall | MEMW_STALL_REQ;

  always @(negedge CLK) if (MEMW_STALL_REQ) stall_cnt++;

  mwrite dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL),
    .MEMR_REG_W_RD(MEMR_REG_W_RD), .MEMR_REG_W_DATA(MEMR_REG_W_DATA),
    .MEMR_MEM_W_VALID(MEMR_MEM_W_VALID), .MEMR_MEM_W_ADDR(MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB(MEMR_MEM_W_STRB), .MEMR_MEM_W_DATA(MEMR_MEM_W_DATA),
    .MEMW_REG_W_RD(MEMW_REG_W_RD), .MEMW_REG_W_DATA(MEMW_REG_W_DATA),
    .MEM_W_VALID(MEM_W_VALID), .MEM_W_READY(MEM_W_READY),
    .MEM_W_ADDR(MEM_W_ADDR), .MEM_W_STRB(MEM_W_STRB), .MEM_W_DATA(MEM_W_DATA),
    .MEM_B_VALID(MEM_B_VALID), .MEM_B_READY(MEM_B_READY), .MEM_B_RESP(MEM_B_RESP),
    .MEMW_STALL_REQ(MEMW_STALL_REQ), .MEMW_FAULT(MEMW_FAULT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd"},     32'(MEMW_REG_W_RD), 32'd0);
    chk({tag, " rdata"},  MEMW_REG_W_DATA, 32'd0);
    chk({tag, " wvalid"}, 32'(MEM_W_VALID), 32'd0);
    chk({tag, " waddr"},  MEM_W_ADDR, 32'd0);
    chk({tag, " wstrb"},  32'(MEM_W_STRB), 32'd0);
    chk({tag, " wdata"},  MEM_W_DATA, 32'd0);
    chk({tag, " bready"}, 32'(MEM_B_READY), 32'd0);
    chk({tag, " stall"},  32'(MEMW_STALL_REQ), 32'd0);
    chk({tag, " fault"},  32'(MEMW_FAULT), 32'd0);
  endtask

  task automatic set_memr(input logic [4:0] rd, input logic [31:0] rdata, input logic v,
                          input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    MEMR_REG_W_RD    = rd;
    MEMR_REG_W_DATA  = rdata;
    MEMR_MEM_W_VALID = v;
    MEMR_MEM_W_ADDR  = a;
    MEMR_MEM_W_STRB  = s;
    MEMR_MEM_W_DATA  = d;
  endtask

  initial begin
    RST_N = 1'b0;
    ext_stall = 1'b0;
    MEM_W_READY = 1'b0;
    MEM_B_VALID = 1'b0;
    MEM_B_RESP = 2'b00;
    set_memr(5'd0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);

    // Power-on reset
    tick();
    chk_all_zero("por");
    tick();
    RST_N = 1'b1;

    // Register-only pass
    set_memr(5'd5, 32'h1234_5678, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    chk("regonly rd", 32'(MEMW_REG_W_RD), 32'd5);
    chk("regonly data", MEMW_REG_W_DATA, 32'h1234_5678);
    chk("regonly wvalid", 32'(MEM_W_VALID), 32'd0);
    chk("regonly stall", 32'(MEMW_STALL_REQ), 32'd0);

    // Store with immediate ready and response
    MEM_W_READY = 1'b1;
    MEM_B_VALID = 1'b1;
    stall_cnt = 0;
    set_memr(5'd0, 32'd0, 1'b1, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF);
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    chk("imm req wvalid", 32'(MEM_W_VALID), 32'd1);
    chk("imm req addr", MEM_W_ADDR, 32'h8000_0010);
    chk("imm req strb", 32'(MEM_W_STRB), 32'hF);
    chk("imm req data", MEM_W_DATA, 32'hDEAD_BEEF);
    chk("imm req bready", 32'(MEM_B_READY), 32'd0);
    chk("imm req stall", 32'(MEMW_STALL_REQ), 32'd1);
    tick();
    chk("imm resp wvalid", 32'(MEM_W_VALID), 32'd0);
    chk("imm resp addr", MEM_W_ADDR, 32'd0);
    chk("imm resp bready", 32'(MEM_B_READY), 32'd1);
    tick();
    chk("imm done bready", 32'(MEM_B_READY), 32'd0);
    chk("imm done stall", 32'(MEMW_STALL_REQ), 32'd0);
    chk("imm stall cycles", 32'(stall_cnt), 32'd2);
    chk("imm fault", 32'(MEMW_FAULT), 32'd0);

    // Backpressure: ready low for 4 REQ cycles, response 3 cycles after acceptance
    MEM_W_READY = 1'b0;
    MEM_B_VALID = 1'b0;
    set_memr(5'd7, 32'h0000_A5A5, 1'b1, 32'h0000_1004, 4'b0011, 32'hCAFE_F00D);
    stall_cnt = 0;
    tick();
    set_memr(5'd9, 32'hFFFF_0000, 1'b1, 32'h1111_2222, 4'b1000, 32'h3333_4444);
    for (int i = 0; i < 4; i++) begin
      chk("bp wvalid", 32'(MEM_W_VALID), 32'd1);
      chk("bp addr", MEM_W_ADDR, 32'h0000_1004);
      chk("bp strb", 32'(MEM_W_STRB), 32'h3);
      chk("bp data", MEM_W_DATA, 32'hCAFE_F00D);
      tick();
    end
    chk("bp last wvalid", 32'(MEM_W_VALID), 32'd1);
    chk("bp last addr", MEM_W_ADDR, 32'h0000_1004);
    MEM_W_READY = 1'b1;
    tick();
    MEM_W_READY = 1'b0;
    chk("bp resp1 bready", 32'(MEM_B_READY), 32'd1);
    chk("bp resp1 wvalid", 32'(MEM_W_VALID), 32'd0);
    tick();
    chk("bp resp2 bready", 32'(MEM_B_READY), 32'd1);
    tick();
    chk("bp resp3 bready", 32'(MEM_B_READY), 32'd1);
    MEM_B_VALID = 1'b1;
    tick();
    MEM_B_VALID = 1'b0;
    chk("bp stall cycles", 32'(stall_cnt), 32'd8);
    chk("bp idle stall", 32'(MEMW_STALL_REQ), 32'd0);
    chk("bp held rd", 32'(MEMW_REG_W_RD), 32'd7);
    chk("bp held data", MEMW_REG_W_DATA, 32'h0000_A5A5);
    set_memr(5'd0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);

    // Error response
    MEM_W_READY = 1'b1;
    MEM_B_VALID = 1'b1;
    MEM_B_RESP  = 2'b10;
    set_memr(5'd0, 32'd0, 1'b1, 32'h0000_2000, 4'b0001, 32'h0000_00AB);
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    chk("err req fault", 32'(MEMW_FAULT), 32'd0);
    tick();
    chk("err resp bready", 32'(MEM_B_READY), 32'd1);
    chk("err resp fault", 32'(MEMW_FAULT), 32'd0);
    tick();
    chk("err pulse", 32'(MEMW_FAULT), 32'd1);
    chk("err idle stall", 32'(MEMW_STALL_REQ), 32'd0);
    tick();
    chk("err pulse end", 32'(MEMW_FAULT), 32'd0);
    chk("err still idle", 32'(MEM_W_VALID), 32'd0);
    MEM_B_RESP  = 2'b00;
    MEM_B_VALID = 1'b0;
    MEM_W_READY = 1'b0;

    // External stall holds the captured values; zero-strobe store still issues
    set_memr(5'd1, 32'h1111_1111, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    chk("xs base rd", 32'(MEMW_REG_W_RD), 32'd1);
    ext_stall = 1'b1;
    set_memr(5'd3, 32'h55AA_55AA, 1'b1, 32'h0000_3000, 4'b0000, 32'h7777_8888);
    tick();
    tick();
    chk("xs hold rd", 32'(MEMW_REG_W_RD), 32'd1);
    chk("xs hold data", MEMW_REG_W_DATA, 32'h1111_1111);
    chk("xs hold wvalid", 32'(MEM_W_VALID), 32'd0);
    chk("xs hold stall", 32'(MEMW_STALL_REQ), 32'd0);
    ext_stall = 1'b0;
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    chk("xs cap rd", 32'(MEMW_REG_W_RD), 32'd3);
    chk("xs cap data", MEMW_REG_W_DATA, 32'h55AA_55AA);
    chk("xs zero-strb wvalid", 32'(MEM_W_VALID), 32'd1);
    chk("xs zero-strb strb", 32'(MEM_W_STRB), 32'd0);
    chk("xs zero-strb addr", MEM_W_ADDR, 32'h0000_3000);
    tick();
    chk("xs req held", 32'(MEM_W_VALID), 32'd1);

    // Asynchronous reset in the middle of REQ
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("rst mid-req");
    tick();
    RST_N = 1'b1;
    MEM_B_VALID = 1'b1;
    tick();
    chk("rst after wvalid", 32'(MEM_W_VALID), 32'd0);
    chk("rst after stall", 32'(MEMW_STALL_REQ), 32'd0);
    chk("rst after bready", 32'(MEM_B_READY), 32'd0);
    MEM_B_VALID = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
